// File: rtl/reg_operand_fetch_pkg.sv
// reg_operand_fetch_pkg
//   Shared definitions for the register operand-fetch front end:
//   default register width / address width and the fetch FSM encoding.
package reg_operand_fetch_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ_A = 2'd1,
    ST_READ_B = 2'd2,
    ST_HOLD   = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/reg_operand_fetch_bypass_sel.sv
// reg_bypass_sel
//   Combinational write-port forwarding for one register address.
//   Ports:
//     wr_en/wr_addr/wr_data : register-file write port being snooped
//     addr                  : register index of interest
//     rd_data               : value read from the file for addr
//     hit                   : a write to addr is happening this cycle
//     data                  : wr_data on a hit, otherwise rd_data
import reg_operand_fetch_pkg::*;

module reg_bypass_sel #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              hit,
  output logic [DATA_W-1:0] data
);

  assign hit  = wr_en && (wr_addr == addr);
  assign data = hit ? wr_data : rd_data;

endmodule

// File: rtl/reg_operand_fetch.sv
// reg_operand_fetch
//   Two-source operand fetch through a single combinational register-file
//   read port. Source A is read in READ_A, source B in READ_B, and the pair is
//   presented in HOLD until the consumer takes it. Writes to the file are
//   snooped so the presented operands always match the committed file state.
//   Ports:
//     clk, rst                      : clock, synchronous active-high reset
//     req_valid/req_ready           : request handshake
//     req_src_a/req_src_b           : source register indices
//     rd_addr/rd_data               : register-file read port
//     wr_en/wr_addr/wr_data         : register-file write port (snooped)
//     op_valid/op_ready, op_a/op_b  : operand pair handshake
import reg_operand_fetch_pkg::*;

module reg_operand_fetch #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_src_a,
  input  logic [ADDR_W-1:0] req_src_b,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] src_a_q, src_a_d;
  logic [ADDR_W-1:0] src_b_q, src_b_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic              op_valid_q, op_valid_d;

  logic              hit_a, hit_b;
  logic [DATA_W-1:0] byp_a, byp_b;
  logic              accept;

  // One selector per latched source: the bypassed value is used for the
  // capture cycle, the hit flag alone drives the later snoop updates.
  reg_bypass_sel #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_sel_a (
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .addr    (src_a_q),
    .rd_data (rd_data),
    .hit     (hit_a),
    .data    (byp_a)
  );

  reg_bypass_sel #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_sel_b (
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .addr    (src_b_q),
    .rd_data (rd_data),
    .hit     (hit_b),
    .data    (byp_b)
  );

  assign req_ready = !rst && ((state_q == ST_IDLE) ||
                              ((state_q == ST_HOLD) && op_ready));
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d    = state_q;
    src_a_d    = src_a_q;
    src_b_d    = src_b_q;
    rd_addr_d  = rd_addr_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_valid_d = op_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          src_a_d   = req_src_a;
          src_b_d   = req_src_b;
          // rd_addr is registered, so it is loaded one edge early to be
          // pointing at source A throughout READ_A.
          rd_addr_d = req_src_a;
          state_d   = ST_READ_A;
        end
      end
      ST_READ_A: begin
        op_a_d    = byp_a;
        rd_addr_d = src_b_q;
        state_d   = ST_READ_B;
      end
      ST_READ_B: begin
        op_b_d = byp_b;
        // rd_data now belongs to source B, so A is refreshed only from the
        // write port.
        if (hit_a) op_a_d = wr_data;
        op_valid_d = 1'b1;
        state_d    = ST_HOLD;
      end
      ST_HOLD: begin
        if (hit_a) op_a_d = wr_data;
        if (hit_b) op_b_d = wr_data;
        if (op_ready) begin
          op_valid_d = 1'b0;
          if (accept) begin
            src_a_d   = req_src_a;
            src_b_d   = req_src_b;
            rd_addr_d = req_src_a;
            state_d   = ST_READ_A;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      src_a_q    <= '0;
      src_b_q    <= '0;
      rd_addr_q  <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_a_q    <= src_a_d;
      src_b_q    <= src_b_d;
      rd_addr_q  <= rd_addr_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_valid_q <= op_valid_d;
    end
  end

  assign rd_addr  = rd_addr_q;
  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign op_valid = op_valid_q;

endmodule

// File: tb/tb_reg_operand_fetch.sv
// tb_reg_operand_fetch
//   Scoreboard bench. A behavioural register file answers the read port and
//   takes writes. Each accepted request is queued with its accept cycle; the
//   monitor expects the pair to be valid from two cycles after acceptance and,
//   at handshake, to equal the file's current contents of both sources.
module tb_reg_operand_fetch;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_src_a, req_src_b;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       op_valid;
  logic       op_ready;
  logic [7:0] op_a, op_b;

  logic [7:0] regs [16];

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    int         acc;
  } req_t;

  req_t q[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  logic busy, hold, exp_rdy;

  reg_operand_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_src_a (req_src_a),
    .req_src_b (req_src_b),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_a      (op_a),
    .op_b      (op_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register file model: combinational read, write at the edge.
  assign rd_data = regs[rd_addr];
  always @(posedge clk) if (wr_en) regs[wr_addr] <= wr_data;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endfunction

  // Monitor: the head request is in flight from its accept edge and its
  // operands are on offer from two cycles later.
  always @(negedge clk) begin
    if (rst) begin
      chk("req_ready_in_rst", {31'd0, req_ready}, 32'd0);
    end else begin
      busy    = (q.size() > 0) && (q[0].acc <= cyc);
      hold    = busy && (cyc >= q[0].acc + 2);
      exp_rdy = !busy || (hold && op_ready);
      chk("req_ready", {31'd0, req_ready}, {31'd0, exp_rdy});
      chk("op_valid", {31'd0, op_valid}, {31'd0, hold});
      if (hold && op_ready) begin
        chk("op_a", {24'd0, op_a}, {24'd0, regs[q[0].a]});
        chk("op_b", {24'd0, op_b}, {24'd0, regs[q[0].b]});
        $display("[TB] cycle %0d: pair a=r%0d b=r%0d -> %02h %02h",
                 cyc, q[0].a, q[0].b, op_a, op_b);
        void'(q.pop_front());
      end
    end
  end

  // One cycle of stimulus, driven just after the edge; an accepted request
  // is queued for the edge that ends this cycle.
  task automatic drive(input logic rv, input logic [3:0] sa, input logic [3:0] sb,
                       input logic we, input logic [3:0] wa, input logic [7:0] wd,
                       input logic ordy);
    req_t r;
    @(posedge clk);
    #1;
    req_valid = rv;
    req_src_a = sa;
    req_src_b = sb;
    wr_en     = we;
    wr_addr   = wa;
    wr_data   = wd;
    op_ready  = ordy;
    #1;
    if (rv && req_ready) begin
      r.a = sa;
      r.b = sb;
      r.acc = cyc + 1;
      q.push_back(r);
    end
  endtask

  task automatic idle(input logic ordy, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 8'd0, ordy);
  endtask

  initial begin
    logic [3:0] sa, sb, wa;
    logic       sm;
    rst = 1'b1;
    req_valid = 1'b0; req_src_a = '0; req_src_b = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; op_ready = 1'b0;

    // Preload the file through the write port while in reset.
    for (int i = 0; i < 16; i++)
      drive(1'b0, 4'd0, 4'd0, 1'b1, 4'(i), 8'($urandom_range(0, 255)), 1'b0);
    drive(1'b0, 4'd0, 4'd0, 1'b1, 4'd3, 8'h11, 1'b0);
    drive(1'b0, 4'd0, 4'd0, 1'b1, 4'd7, 8'h22, 1'b0);
    drive(1'b0, 4'd0, 4'd0, 1'b1, 4'd4, 8'h0F, 1'b0);

    @(posedge clk); #1;
    rst = 1'b0; wr_en = 1'b0;
    #1;
    chk("rst_op_valid", {31'd0, op_valid}, 32'd0);
    chk("rst_op_a", {24'd0, op_a}, 32'd0);
    chk("rst_op_b", {24'd0, op_b}, 32'd0);
    chk("rst_rd_addr", {28'd0, rd_addr}, 32'd0);
    chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

    // Plain fetch r3/r7.
    drive(1'b1, 4'd3, 4'd7, 1'b0, 4'd0, 8'd0, 1'b1);
    idle(1'b1, 4);
    // Same fetch with a write to r3 during READ_A (must forward 0x5A).
    drive(1'b1, 4'd3, 4'd7, 1'b0, 4'd0, 8'd0, 1'b1);
    drive(1'b0, 4'd0, 4'd0, 1'b1, 4'd3, 8'h5A, 1'b1);
    idle(1'b1, 3);
    // Same source twice, snooped in HOLD while the consumer stalls.
    drive(1'b1, 4'd4, 4'd4, 1'b0, 4'd0, 8'd0, 1'b0);
    idle(1'b0, 2);
    drive(1'b0, 4'd0, 4'd0, 1'b1, 4'd4, 8'hF0, 1'b0);
    idle(1'b0, 1);
    chk("hold_snoop_a", {24'd0, op_a}, 32'hF0);
    chk("hold_snoop_b", {24'd0, op_b}, 32'hF0);
    idle(1'b0, 1);
    idle(1'b1, 2);
    // Back-to-back: second request accepted in the HOLD handshake cycle.
    drive(1'b1, 4'd3, 4'd7, 1'b0, 4'd0, 8'd0, 1'b1);
    idle(1'b1, 2);
    drive(1'b1, 4'd1, 4'd2, 1'b0, 4'd0, 8'd0, 1'b1);
    idle(1'b1, 4);
    // Unrelated write to r9 throughout the fetch.
    drive(1'b1, 4'd3, 4'd7, 1'b0, 4'd0, 8'd0, 1'b0);
    drive(1'b0, 4'd0, 4'd0, 1'b1, 4'd9, 8'hC3, 1'b0);
    drive(1'b0, 4'd0, 4'd0, 1'b1, 4'd9, 8'hC4, 1'b0);
    drive(1'b0, 4'd0, 4'd0, 1'b1, 4'd9, 8'hC5, 1'b1);
    idle(1'b1, 2);

    // Reset while in READ_B: in-flight request is dropped.
    drive(1'b1, 4'd3, 4'd7, 1'b0, 4'd0, 8'd0, 1'b1);
    idle(1'b1, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    q.delete();
    #1;
    chk("rst_readb_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #2;
    chk("rst_readb_valid", {31'd0, op_valid}, 32'd0);
    chk("rst_readb_op_a", {24'd0, op_a}, 32'd0);
    chk("rst_readb_op_b", {24'd0, op_b}, 32'd0);
    chk("rst_readb_ready_hi", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_release_ready", {31'd0, req_ready}, 32'd1);
    idle(1'b1, 1);

    // Random traffic; narrow-address mode makes snoop hits frequent.
    for (int n = 0; n < 600; n++) begin
      sm = ($urandom_range(0, 1) == 1);
      sa = sm ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      sb = sm ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      wa = sm ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      drive(($urandom_range(0, 9) < 6), sa, sb, ($urandom_range(0, 1) == 1), wa,
            8'($urandom_range(0, 255)), ($urandom_range(0, 9) < 7));
    end

    idle(1'b1, 8);
    chk("drain_queue_empty", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
